mode_switch_conditioner: RTL

//   Conditions the raw board mode switch (encode/decode select) before the mode-indicator LED stage.

---
 rtl/mode_switch_conditioner_if.sv | 24 ++
 rtl/mode_switch_conditioner.sv | 103 ++++++++++
 2 files changed

// File: rtl/mode_switch_conditioner_if.sv
// Signal bundle between the board mode switch / Morse engine side and the mode conditioner.
interface mode_switch_conditioner_if;
    logic sw_raw;
    logic busy;
    logic mode;
    logic mode_change;
    logic pending;

    modport master (
        output sw_raw,
        output busy,
        input  mode,
        input  mode_change,
        input  pending
    );

    modport slave (
        input  sw_raw,
        input  busy,
        output mode,
        output mode_change,
        output pending
    );
endinterface

// File: rtl/mode_switch_conditioner.sv
// Synchronises and debounces the raw mode switch, then commits the clean level to `mode`
// only while the Morse engine is idle, pulsing mode_change once per commit.
module mode_switch_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mode_switch_conditioner_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StIdle, StWait} state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   deb_q, deb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic                   mode_change_q, mode_change_d;
    logic                   pending_q, pending_d;
    logic                   diff;
    logic                   can_commit;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.sw_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    // Any matching sample throws away the accumulated count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            deb_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign diff = (deb_q != mode_q);
    // Blocking a commit right after another keeps mode_change from running two cycles back to back.
    assign can_commit = !bus.busy && !mode_change_q;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (diff) begin
                    if (can_commit) begin
                        mode_d        = deb_q;
                        mode_change_d = 1'b1;
                    end else if (bus.busy) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!diff) begin
                    state_d = StIdle;
                end else if (can_commit) begin
                    mode_d        = deb_q;
                    mode_change_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pending_d = (deb_d != mode_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            deb_q         <= 1'b0;
            cnt_q         <= '0;
            state_q       <= StIdle;
            mode_q        <= 1'b0;
            mode_change_q <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            deb_q         <= deb_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            pending_q     <= pending_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.mode_change = mode_change_q;
    assign bus.pending     = pending_q;

endmodule
